// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seven_segment_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

   // Segment order is {a,b,c,d,e,f,g,h}, active-high, 'a' in the MSB.
   localparam logic [7:0] seg_blank = 8'h00;

   localparam logic [7:0] seg_hex [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

   // Glyph for a hex nibble.
   function automatic logic [7:0] hex_glyph(input logic [3:0] value);
      return seg_hex[value];
   endfunction

   // Clock cycles per digit slot.
   function automatic int period_cycles(input int clk_mhz, input int digit_hz);
      return (clk_mhz * 1000000) / digit_hz;
   endfunction

endpackage

// File: rtl/seg_double_buffer.sv
// Shadow/active segment store. Writers fill the shadow; a commit request
// copies the whole shadow into the active copy at the next boundary, so
// the scanner never shows a half-updated frame.
module seg_double_buffer
   import seven_segment_pkg::*;
#(
   parameter int w_digit = 6,
   parameter int w_idx   = $clog2(w_digit)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [w_idx-1:0] wr_idx,
   input  logic [7:0]       wr_seg,
   input  logic             wr_commit,
   input  logic             boundary,
   input  logic [w_idx-1:0] rd_idx,
   output logic [7:0]       rd_seg
);

   localparam logic [w_idx:0] n_digit = (w_idx + 1)'(w_digit);

   logic [7:0] shadow_q [w_digit];
   logic [7:0] active_q [w_digit];
   logic       pending_q;
   logic       accept;
   logic       in_range;
   logic       copy;

   assign wr_ready = ~pending_q;
   assign accept   = wr_valid & wr_ready;
   assign in_range = ({1'b0, wr_idx} < n_digit);
   assign copy     = boundary & pending_q;

   // During the copy cycle the reader sees the shadow, so the slot that
   // starts on that edge already shows the freshly committed frame.
   assign rd_seg = copy ? shadow_q[rd_idx] : active_q[rd_idx];

   // Shadow writes, commit tracking and the frame-wide shadow-to-active copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: both buffers are cleared by reset because a reset must blank the display; plain storage arrays normally stay unreset.
         for (int i = 0; i < w_digit; i++) begin
            shadow_q[i] <= seg_blank;
            active_q[i] <= seg_blank;
         end
         pending_q <= 1'b0;
      end else begin
         if (accept && in_range) begin
            shadow_q[wr_idx] <= wr_seg;
         end
         if (copy) begin
            for (int i = 0; i < w_digit; i++) begin
               active_q[i] <= shadow_q[i];
            end
         end
         if (copy) begin
            pending_q <= 1'b0;
         end else if (accept && wr_commit) begin
            pending_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_segment_scheduler.sv
// Time-multiplexed 7-segment scanner: shows each digit for a slot, then a
// dead-time blank, cycling through all digits. Outputs are registered and
// computed from the next state so digit and segments switch together.
module seven_segment_scheduler
   import seven_segment_pkg::*;
#(
   parameter int clk_mhz      = 50,
   parameter int w_digit      = 6,
   parameter int digit_hz     = 1000,
   parameter int blank_cycles = 500,
   parameter int w_idx        = $clog2(w_digit)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [w_idx-1:0]   wr_idx,
   input  logic [7:0]         wr_seg,
   input  logic               wr_commit,
   input  logic [w_digit-1:0] blank_mask,
   output logic [7:0]         abcdefgh,
   output logic [w_digit-1:0] digit,
   output logic               frame_done
);

   localparam int period      = period_cycles(clk_mhz, digit_hz);
   localparam int show_cycles = period - blank_cycles;
   localparam int w_cnt       = $clog2(period);

   localparam logic [w_cnt-1:0] show_last  = w_cnt'(show_cycles - 1);
   localparam logic [w_cnt-1:0] blank_last = w_cnt'(blank_cycles - 1);
   localparam logic [w_idx-1:0] last_idx   = w_idx'(w_digit - 1);

   state_t             state_q, state_n;
   logic [w_idx-1:0]   idx_q, idx_n;
   logic [w_cnt-1:0]   cnt_q, cnt_n;
   logic               frame_end;
   logic               boundary;
   logic [7:0]         rd_seg;
   logic [7:0]         seg_d;
   logic [w_digit-1:0] digit_d;
   logic               frame_done_d;

   // Last blank cycle of the last digit while scanning: the frame boundary.
   assign frame_end = en && (state_q == BLANK) && (cnt_q == blank_last) && (idx_q == last_idx);
   assign boundary  = frame_end || (state_q == IDLE);

   seg_double_buffer #(
      .w_digit (w_digit),
      .w_idx   (w_idx)
   ) u_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_idx    (wr_idx),
      .wr_seg    (wr_seg),
      .wr_commit (wr_commit),
      .boundary  (boundary),
      .rd_idx    (idx_n),
      .rd_seg    (rd_seg)
   );

   // State, digit index and phase counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q <= state_n;
         idx_q   <= idx_n;
         cnt_q   <= cnt_n;
      end
   end

   // Next state: slot sequencing, index advance and counter wrap at slot end.
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      state_n = state_q;
      idx_n   = idx_q;
      cnt_n   = cnt_q + 1'b1;
      if (!en) begin
         state_n = IDLE;
         idx_n   = '0;
         cnt_n   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_n = SHOW;
               idx_n   = '0;
               cnt_n   = '0;
            end
            SHOW: begin
               if (cnt_q == show_last) begin
                  state_n = BLANK;
                  cnt_n   = '0;
               end
            end
            BLANK: begin
               if (cnt_q == blank_last) begin
                  state_n = SHOW;
                  cnt_n   = '0;
                  idx_n   = (idx_q == last_idx) ? '0 : idx_q + 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               idx_n   = '0;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Output decode for the upcoming cycle, so the output register tracks the state.
   always_comb begin
      digit_d      = '0;
      seg_d        = seg_blank;
      frame_done_d = (state_n == BLANK) && (cnt_n == blank_last) && (idx_n == last_idx);
      if ((state_n == SHOW) && !blank_mask[idx_n]) begin
         digit_d = w_digit'(1) << idx_n;
         seg_d   = rd_seg;
      end
   end

   // Output register: digit and segments switch on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit      <= '0;
         abcdefgh   <= seg_blank;
         frame_done <= 1'b0;
      end else begin
         digit      <= digit_d;
         abcdefgh   <= seg_d;
         frame_done <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_seven_segment_scheduler.sv
// Directed bench for seven_segment_scheduler: 10-cycle slots (8 shown,
// 2 blank), six digits, so one frame is 60 cycles.
module tb_seven_segment_scheduler;
   import seven_segment_pkg::*;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b1;
   logic       en         = 1'b0;
   logic       wr_valid   = 1'b0;
   logic [2:0] wr_idx     = '0;
   logic [7:0] wr_seg     = '0;
   logic       wr_commit  = 1'b0;
   logic [5:0] blank_mask = '0;
   logic       wr_ready;
   logic [7:0] abcdefgh;
   logic [5:0] digit;
   logic       frame_done;

   int n_cmp = 0;
   int n_err = 0;
   int k     = 0;              // cycles observed since scanning was enabled
   logic [7:0] tab [6];        // expected displayed glyph per digit

   always #5 clk = ~clk;

   seven_segment_scheduler #(
      .clk_mhz      (1),
      .w_digit      (6),
      .digit_hz     (100000),
      .blank_cycles (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_idx     (wr_idx),
      .wr_seg     (wr_seg),
      .wr_commit  (wr_commit),
      .blank_mask (blank_mask),
      .abcdefgh   (abcdefgh),
      .digit      (digit),
      .frame_done (frame_done)
   );

   // Expected {digit, abcdefgh, frame_done} at scan cycle kk.
   function automatic logic [14:0] exp_out(input int kk, input logic [5:0] mask);
      int s, p;
      logic [5:0] d;
      logic [7:0] sg;
      s  = ((kk - 1) % 60) / 10;
      p  = (kk - 1) % 10;
      d  = '0;
      sg = '0;
      if (p < 8 && !mask[s]) begin
         d  = 6'(1 << s);
         sg = tab[s];
      end
      return {d, sg, ((kk % 60) == 0)};
   endfunction

   task automatic step();
      @(negedge clk);
      k++;
   endtask

   task automatic start_scan(input logic enable);
      rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0; wr_commit = 1'b0; blank_mask = '0;
      @(negedge clk);
      rst_n = 1'b1;
      en    = enable;
      k     = 0;
      foreach (tab[i]) tab[i] = 8'h00;
   endtask

   task automatic drive_write(input int idx, input logic [7:0] seg, input logic commit);
      wr_valid = 1'b1; wr_idx = 3'(idx); wr_seg = seg; wr_commit = commit;
      step();
      wr_valid = 1'b0; wr_commit = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {6'd0, 8'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values got=%h want=%h", {digit, abcdefgh, frame_done, wr_ready}, {6'd0, 8'd0, 1'b0, 1'b1});
         end
      end
      en = 1'b0;
   endtask

   task automatic test_scan();
      start_scan(1'b1);
      while (k < 120) begin
         step();
         n_cmp++;
         if ({digit, abcdefgh, frame_done} !== exp_out(k, 6'b0)) begin
            n_err++;
            $display("FAIL scan k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done}, exp_out(k, 6'b0));
         end
      end
   endtask

   task automatic test_commit();
      start_scan(1'b1);
      step(); step();
      drive_write(0, hex_glyph(4'h0), 1'b0);
      drive_write(5, hex_glyph(4'h1), 1'b0);
      drive_write(1, hex_glyph(4'h2), 1'b1);
      n_cmp++;
      if (wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL commit_ready_low got=%b want=0", wr_ready);
      end
      while (k < 120) begin
         step();
         if (k == 61) begin
            tab[0] = 8'hFC; tab[1] = 8'hDA; tab[5] = 8'h60;
         end
         n_cmp++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_out(k, 6'b0), (k >= 61)}) begin
            n_err++;
            $display("FAIL commit k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done, wr_ready}, {exp_out(k, 6'b0), (k >= 61)});
         end
      end
   endtask

   task automatic test_back_to_back();
      start_scan(1'b1);
      step(); step();
      drive_write(2, 8'h9E, 1'b1);
      wr_valid = 1'b1; wr_idx = 3'd2; wr_seg = 8'h0E; wr_commit = 1'b1;
      while (k < 180) begin
         step();
         if (k == 61)  tab[2] = 8'h9E;
         if (k == 121) tab[2] = 8'h0E;
         n_cmp++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_out(k, 6'b0), ((k == 61) || (k >= 121))}) begin
            n_err++;
            $display("FAIL held_write k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done, wr_ready}, {exp_out(k, 6'b0), ((k == 61) || (k >= 121))});
         end
         if (k == 62) begin
            wr_valid = 1'b0; wr_commit = 1'b0;
         end
      end
   endtask

   task automatic test_mask();
      logic [5:0] m;
      start_scan(1'b0);
      drive_write(1, 8'h60, 1'b0);
      drive_write(2, 8'hFF, 1'b1);
      n_cmp++;
      if ({digit, abcdefgh, wr_ready} !== {6'd0, 8'd0, 1'b0}) begin
         n_err++;
         $display("FAIL idle_commit_pending got=%h want=%h", {digit, abcdefgh, wr_ready}, {6'd0, 8'd0, 1'b0});
      end
      step();
      n_cmp++;
      if ({digit, abcdefgh, wr_ready} !== {6'd0, 8'd0, 1'b1}) begin
         n_err++;
         $display("FAIL idle_commit_copied got=%h want=%h", {digit, abcdefgh, wr_ready}, {6'd0, 8'd0, 1'b1});
      end
      blank_mask = 6'b000100;
      en = 1'b1;
      k  = 0;
      tab[1] = 8'h60; tab[2] = 8'hFF;
      while (k < 120) begin
         step();
         m = (k <= 60) ? 6'b000100 : 6'b000000;
         n_cmp++;
         if ({digit, abcdefgh, frame_done} !== exp_out(k, m)) begin
            n_err++;
            $display("FAIL mask k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done}, exp_out(k, m));
         end
         if (k == 60) blank_mask = 6'b000000;
      end
   endtask

   task automatic test_en_drop();
      start_scan(1'b1);
      step(); step();
      drive_write(3, 8'hF2, 1'b1);
      while (k < 33) begin
         step();
         n_cmp++;
         if ({digit, abcdefgh, frame_done} !== exp_out(k, 6'b0)) begin
            n_err++;
            $display("FAIL pre_drop k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done}, exp_out(k, 6'b0));
         end
      end
      en = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         n_cmp++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {6'd0, 8'd0, 1'b0, (j >= 2)}) begin
            n_err++;
            $display("FAIL en_drop j=%0d got=%h want=%h", j, {digit, abcdefgh, frame_done, wr_ready}, {6'd0, 8'd0, 1'b0, (j >= 2)});
         end
      end
      en = 1'b1;
      k  = 0;
      tab[3] = 8'hF2;
      while (k < 60) begin
         step();
         n_cmp++;
         if ({digit, abcdefgh, frame_done} !== exp_out(k, 6'b0)) begin
            n_err++;
            $display("FAIL re_enable k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done}, exp_out(k, 6'b0));
         end
      end
   endtask

   task automatic test_reset_mid();
      start_scan(1'b1);
      step(); step();
      drive_write(0, 8'hB6, 1'b1);
      while (k < 64) begin
         step();
         if (k == 61) tab[0] = 8'hB6;
         n_cmp++;
         if ({digit, abcdefgh, frame_done} !== exp_out(k, 6'b0)) begin
            n_err++;
            $display("FAIL pre_reset k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done}, exp_out(k, 6'b0));
         end
      end
      drive_write(1, 8'h66, 1'b1);
      n_cmp++;
      if (wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL pre_reset_pending got=%b want=0", wr_ready);
      end
      while (k < 69) step();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({digit, abcdefgh, frame_done, wr_ready} !== {6'd0, 8'd0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL async_reset got=%h want=%h", {digit, abcdefgh, frame_done, wr_ready}, {6'd0, 8'd0, 1'b0, 1'b1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      foreach (tab[i]) tab[i] = 8'h00;
      while (k < 2) begin
         step();
         n_cmp++;
         if ({digit, abcdefgh, frame_done} !== exp_out(k, 6'b0)) begin
            n_err++;
            $display("FAIL post_reset k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done}, exp_out(k, 6'b0));
         end
      end
      drive_write(7, 8'hFF, 1'b1);
      n_cmp++;
      if (wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL idx7_accepted got=%b want=0", wr_ready);
      end
      while (k < 120) begin
         step();
         n_cmp++;
         if ({digit, abcdefgh, frame_done, wr_ready} !== {exp_out(k, 6'b0), (k >= 61)}) begin
            n_err++;
            $display("FAIL idx7_ignored k=%0d got=%h want=%h", k, {digit, abcdefgh, frame_done, wr_ready}, {exp_out(k, 6'b0), (k >= 61)});
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_scan();
      test_commit();
      test_back_to_back();
      test_mask();
      test_en_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
